// File: rtl/glb_load_sequencer.sv
// Streams one layer's ifmap, weight and bias words from DRAM into the GLB SRAMs in fixed order,
// backing off whenever the compute path claims the SRAMs.
module glb_load_sequencer #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int IFMAP_DEPTH  = 32,
    parameter int WEIGHT_DEPTH = 1024,
    parameter int BIAS_DEPTH   = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] ifmap_len,
    input  logic [ADDR_W-1:0] weight_len,
    input  logic [ADDR_W-1:0] bias_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              glb_busy,
    output logic              ifmap_wen,
    output logic              weight_wen,
    output logic              bias_wen,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              load_done,
    output logic              cfg_err
);

    // state | meaning: IDLE wait start; LD_* streaming a region; DONE one-cycle completion
    typedef enum logic [2:0] {IDLE, LD_IFMAP, LD_WEIGHT, LD_BIAS, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, ifmap_len_q, weight_len_q, bias_len_q, cur_len;
    logic              xfer, last, len_bad, start_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        len_bad  = (ifmap_len > ADDR_W'(IFMAP_DEPTH)) || (weight_len > ADDR_W'(WEIGHT_DEPTH))
                || (bias_len > ADDR_W'(BIAS_DEPTH));
        start_ok = (state == IDLE) && start && !len_bad;
        in_ready = ((state == LD_IFMAP) || (state == LD_WEIGHT) || (state == LD_BIAS)) && !glb_busy;
        xfer     = in_valid && in_ready;
        cur_len  = '0;
        case (state)
            LD_IFMAP:  cur_len = ifmap_len_q;
            LD_WEIGHT: cur_len = weight_len_q;
            LD_BIAS:   cur_len = bias_len_q;
            default:   cur_len = '0;
        endcase
        last      = xfer && (cnt == cur_len - 1'b1);
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    if (ifmap_len != '0)       state_nxt = LD_IFMAP;
                    else if (weight_len != '0) state_nxt = LD_WEIGHT;
                    else if (bias_len != '0)   state_nxt = LD_BIAS;
                    else                       state_nxt = DONE;
                end
            end
            LD_IFMAP: begin
                if (last) begin
                    if (weight_len_q != '0)    state_nxt = LD_WEIGHT;
                    else if (bias_len_q != '0) state_nxt = LD_BIAS;
                    else                       state_nxt = DONE;
                end
            end
            LD_WEIGHT: begin
                if (last) state_nxt = (bias_len_q != '0) ? LD_BIAS : DONE;
            end
            LD_BIAS: begin
                if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            ifmap_len_q  <= '0;
            weight_len_q <= '0;
            bias_len_q   <= '0;
        end else if (start_ok) begin
            cnt          <= '0;
            ifmap_len_q  <= ifmap_len;
            weight_len_q <= weight_len;
            bias_len_q   <= bias_len;
        end else if (xfer) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    // Write port is one cycle behind the handshake; address/data hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifmap_wen  <= 1'b0;
            weight_wen <= 1'b0;
            bias_wen   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cfg_err    <= 1'b0;
        end else begin
            ifmap_wen  <= xfer && (state == LD_IFMAP);
            weight_wen <= xfer && (state == LD_WEIGHT);
            bias_wen   <= xfer && (state == LD_BIAS);
            cfg_err    <= (state == IDLE) && start && len_bad;
            if (xfer) begin
                wr_addr <= cnt;
                wr_data <= in_data;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign load_done = (state == DONE);

endmodule

// File: tb/tb_glb_load_sequencer.sv
// Scoreboard bench for glb_load_sequencer: the driver queues expected writes, a negedge monitor checks them.
module tb_glb_load_sequencer;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] ifmap_len = '0, weight_len = '0, bias_len = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              glb_busy = 1'b0;
    logic              ifmap_wen, weight_wen, bias_wen;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy, load_done, cfg_err;

    glb_load_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .ifmap_len(ifmap_len), .weight_len(weight_len), .bias_len(bias_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .glb_busy(glb_busy),
        .ifmap_wen(ifmap_wen), .weight_wen(weight_wen), .bias_wen(bias_wen),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .load_done(load_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        region;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  errors = 0;
    int  checks = 0;
    int  done_cnt = 0;
    int  err_cnt = 0;
    logic prev_gb = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe pops one expected write.
    always @(negedge clk) begin
        if (rst) begin
            prev_gb <= 1'b0;
        end else begin
            int  n;
            wr_t e;
            wr_t a;
            n = int'(ifmap_wen) + int'(weight_wen) + int'(bias_wen);
            if (prev_gb) chk("no_wen_after_glb_busy", 64'(n), 64'd0);
            if (n > 1) chk("wen_onehot", 64'(n), 64'd1);
            if (n != 0) begin
                a.region = ifmap_wen ? 2'd0 : (weight_wen ? 2'd1 : 2'd2);
                a.addr   = wr_addr;
                a.data   = wr_data;
                if (sb.size() == 0) begin
                    chk("unexpected_write", 64'(a), 64'h0);
                end else begin
                    e = sb.pop_front();
                    chk("write_region", 64'(a.region), 64'(e.region));
                    chk("write_addr", 64'(a.addr), 64'(e.addr));
                    chk("write_data", 64'(a.data), 64'(e.data));
                end
            end
            if (load_done) begin
                done_cnt++;
                chk("done_with_all_written", 64'(sb.size()), 64'd0);
            end
            if (cfg_err) err_cnt++;
            prev_gb <= glb_busy;
        end
    end

    // Drives one load; stops after stop_at transfers. inj_start pulses a bogus start mid weight region.
    task automatic run_load(input int il, input int wl, input int bl, input bit tog, input bit gaps,
                            input int stop_at, input bit inj_start);
        int  total, idx, d0;
        bit  xfer, injected;
        wr_t e;
        total = il + wl + bl;
        for (int i = 0; i < total; i++) begin
            e.data = DATA_W'(32'hA0 + i);
            if (i < il)           begin e.region = 2'd0; e.addr = ADDR_W'(i); end
            else if (i < il + wl) begin e.region = 2'd1; e.addr = ADDR_W'(i - il); end
            else                  begin e.region = 2'd2; e.addr = ADDR_W'(i - il - wl); end
            sb.push_back(e);
        end
        d0 = done_cnt;
        idx = 0;
        injected = 0;
        ifmap_len = ADDR_W'(il); weight_len = ADDR_W'(wl); bias_len = ADDR_W'(bl);
        for (int c = 0; c < 5000 && (c == 0 || idx < stop_at); c++) begin
            start = (c == 0);
            if (inj_start && !injected && idx == il + 1) begin
                start = 1'b1; injected = 1;
                ifmap_len = 5; weight_len = 5; bias_len = 5;
            end
            glb_busy = tog ? c[0] : 1'b0;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = DATA_W'(32'hA0 + idx);
            @(negedge clk);
            xfer = in_valid && in_ready;
            @(posedge clk); #1;
            if (xfer) idx++;
        end
        start = 1'b0; in_valid = 1'b0; glb_busy = 1'b0;
        chk("xfer_count", 64'(idx), 64'(stop_at));
        if (stop_at == total && total > 0) begin
            @(negedge clk);
            chk("done_after_last", 64'(load_done), 64'd1);
            chk("busy_in_done", 64'(busy), 64'd1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("busy_drop", 64'(busy), 64'd0);
            chk("single_done", 64'(done_cnt - d0), 64'd1);
            chk("sb_empty", 64'(sb.size()), 64'd0);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, {in_ready, ifmap_wen, weight_wen, bias_wen, busy, load_done, cfg_err,
                   wr_addr, wr_data}, 64'd0);
    endtask

    initial begin
        int e0;
        #2;
        check_outputs_zero("reset_outputs");
        #20;
        @(posedge clk); #1; rst = 1'b0;

        // basic load, in_valid high with start
        run_load(2, 3, 1, 0, 0, 6, 0);
        // stalls from glb_busy toggle and random in_valid gaps
        run_load(2, 3, 1, 1, 1, 6, 0);
        // only bias
        run_load(0, 0, 2, 0, 0, 2, 0);

        // all lengths zero
        ifmap_len = 0; weight_len = 0; bias_len = 0; start = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("zero_len_done", 64'(load_done), 64'd1);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("zero_len_idle", 64'(busy), 64'd0);

        // oversized weight length
        e0 = err_cnt;
        weight_len = 1025; ifmap_len = 2; bias_len = 1; start = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
        chk("cfg_err_busy", 64'(busy), 64'd0);
        chk("cfg_err_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1; in_valid = 1'b0;
        @(negedge clk);
        chk("cfg_err_once", 64'(err_cnt - e0), 64'd1);
        chk("cfg_err_busy_after", 64'(busy), 64'd0);
        run_load(2, 3, 1, 0, 0, 6, 0);

        // async reset in weight region once 500 weight words have transferred
        run_load(2, 1000, 1, 0, 0, 502, 0);
        #1; rst = 1'b1;
        #1;
        check_outputs_zero("async_reset_outputs");
        sb.delete();
        @(posedge clk); #1; rst = 1'b0;
        run_load(2, 3, 1, 0, 0, 6, 0);

        // stray start during weight region
        e0 = err_cnt;
        run_load(2, 3, 1, 0, 0, 6, 1);
        chk("stray_start_no_err", 64'(err_cnt - e0), 64'd0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
